// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I writeback encodings
// Purpose: writeback result-select encodings and load funct3 codes shared
//          by the writeback stage and its load extension helper.
// Ports:   none (package).
package riscv_pkg;

    // Writeback result source select; the unused 2'b11 code behaves as ALU.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

    // Load size/sign codes (funct3 of the load opcode).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select and sign/zero extension
// Purpose: picks the byte/halfword lane out of an aligned memory word and
//          extends it to 32 bits according to the load funct3.
// Ports:   i_data   - raw aligned word from data memory
//          i_offset - byte offset within the word (address bits [1:0])
//          i_funct3 - load size/sign code
//          o_data   - extended load result
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        case (i_offset)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
    end

    // Only offset bit 1 picks the halfword; misaligned halfwords trap
    // upstream so bit 0 is don't-care here.
    assign w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'd0, w_half};
            F3_LW:   o_data = i_data;
            default: o_data = i_data;   // undefined load codes pass the raw word
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - RV32I writeback stage and integer register file
// Purpose: selects/extends the writeback result, commits it to the 32x32
//          register file, serves two decode read ports with write-first
//          bypass, and counts retired instructions.
// Ports:   clk, rst (async, active-low)
//          ValidW, RegWriteW, ResultSrcW, Funct3W, ALUResultW, ReadDataW,
//          PCPlus4W, rdW  - MEM/WB pipeline register outputs
//          rs1D, rs2D     - decode source indices
//          RD1D, RD2D     - decode source operands
//          ResultW        - writeback value (also to forwarding muxes)
//          InstRetW       - 64-bit retired-instruction count
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidW,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [2:0]      Funct3W,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      rdW,
    input  logic [4:0]      rs1D,
    input  logic [4:0]      rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [63:0]     InstRetW
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [63:0]     r_instret;
    logic [XLEN-1:0] w_load;
    logic            w_we;

    load_extend u_load_extend (
        .i_data   (ReadDataW),
        .i_offset (ALUResultW[1:0]),
        .i_funct3 (Funct3W),
        .o_data   (w_load)
    );

    always_comb begin
        ResultW = ALUResultW;
        case (result_src_e'(ResultSrcW))
            RES_LOAD: ResultW = w_load;
            RES_PC4:  ResultW = PCPlus4W;
            default:  ResultW = ALUResultW;
        endcase
    end

    // x0 is never written, so its slot stays at its reset value of zero.
    assign w_we = ValidW & RegWriteW & (rdW != 5'd0);

    // Flip-flop array rather than RAM so the whole file clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[rdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (ValidW) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign InstRetW = r_instret;

    // Write-first bypass: a same-cycle commit to the source register is
    // forwarded so decode never sees the stale array value. Reads return
    // zero while reset is held.
    always_comb begin
        RD1D = '0;
        if (rst && rs1D != 5'd0) begin
            RD1D = (w_we && rs1D == rdW) ? ResultW : r_regs[rs1D];
        end
    end

    always_comb begin
        RD2D = '0;
        if (rst && rs2D != 5'd0) begin
            RD2D = (w_we && rs2D == rdW) ? ResultW : r_regs[rs2D];
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard bench for writeback_regfile
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [2:0]  Funct3W;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  rdW, rs1D, rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;

    writeback_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .Funct3W    (Funct3W),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .rdW        (rdW),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .InstRetW   (InstRetW)
    );

    always #5 clk = ~clk;

    localparam int S_RD1 = 0, S_RD2 = 1, S_RES = 2, S_RET = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } chk_t;

    chk_t sb[$];
    event ev_chk;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void expect_val(string n, int s, logic [63:0] v);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = v;
        sb.push_back(c);
    endfunction

    // Monitor: drains pending expectations at each falling edge, or on demand
    // for checks that must happen between clock edges.
    initial begin
        forever begin
            @(negedge clk or ev_chk);
            while (sb.size() > 0) begin
                chk_t        c;
                logic [63:0] act;
                c = sb.pop_front();
                case (c.sel)
                    S_RD1:   act = {32'd0, RD1D};
                    S_RD2:   act = {32'd0, RD2D};
                    S_RES:   act = {32'd0, ResultW};
                    default: act = InstRetW;
                endcase
                n_cmp++;
                if (act !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; Funct3W = 3'b000;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0;
        rdW = '0; rs1D = '0; rs2D = '0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] a, input logic [4:0] b);
        ValidW = 1'b1; RegWriteW = 1'b1; ResultSrcW = 2'b00;
        ALUResultW = v; rdW = rd; rs1D = a; rs2D = b;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp, input string n);
        idle();
        ResultSrcW = 2'b01; ReadDataW = 32'h80FF7F01;
        Funct3W = f3; ALUResultW = {30'd0, off};
        expect_val(n, S_RES, {32'd0, exp});
    endtask

    initial begin
        idle();
        rst = 1'b0;

        // Reset held: writes ignored, reads zero, result still combinational.
        step();
        wr(5'd5, 32'h12345678, 5'd5, 5'd5);
        expect_val("rst_rd1", S_RD1, 64'd0);
        expect_val("rst_rd2", S_RD2, 64'd0);
        expect_val("rst_ret", S_RET, 64'd0);
        expect_val("rst_res", S_RES, 64'h12345678);
        step();
        expect_val("rst_ret_edge", S_RET, 64'd0);
        expect_val("rst_rd1_edge", S_RD1, 64'd0);

        // Release; first commit happens on the next edge.
        step();
        rst = 1'b1;
        expect_val("rel_bypass", S_RD1, 64'h12345678);
        expect_val("rel_ret", S_RET, 64'd0);
        step();
        idle(); rs1D = 5'd5;
        expect_val("x5_array", S_RD1, 64'h12345678);
        expect_val("x5_rd2_x0", S_RD2, 64'd0);
        expect_val("ret_1", S_RET, 64'd1);

        // Load extension of 0x80FF7F01.
        step(); ld(3'b000, 2'd3, 32'hFFFFFF80, "lb_o3");
        step(); ld(3'b000, 2'd0, 32'h00000001, "lb_o0");
        step(); ld(3'b000, 2'd2, 32'hFFFFFFFF, "lb_o2");
        step(); ld(3'b100, 2'd1, 32'h0000007F, "lbu_o1");
        step(); ld(3'b001, 2'd2, 32'hFFFF80FF, "lh_o2");
        step(); ld(3'b001, 2'd3, 32'hFFFF80FF, "lh_o3");
        step(); ld(3'b101, 2'd0, 32'h00007F01, "lhu_o0");
        step(); ld(3'b010, 2'd2, 32'h80FF7F01, "lw_o2");
        step(); ld(3'b011, 2'd1, 32'h80FF7F01, "f3_011_raw");
        step(); idle(); ResultSrcW = 2'b10; PCPlus4W = 32'h00001004; ALUResultW = 32'h5;
        expect_val("sel_pc4", S_RES, 64'h00001004);
        step(); idle(); ResultSrcW = 2'b11; ALUResultW = 32'h0BADF00D; ReadDataW = 32'h1;
        expect_val("sel_rsvd", S_RES, 64'h0BADF00D);

        // Same-cycle bypass on both ports.
        step(); idle(); wr(5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
        expect_val("byp_rd1", S_RD1, 64'hDEADBEEF);
        expect_val("byp_rd2", S_RD2, 64'hDEADBEEF);
        expect_val("byp_ret", S_RET, 64'd1);
        step(); idle(); rs1D = 5'd7; rs2D = 5'd5;
        expect_val("x7_array", S_RD1, 64'hDEADBEEF);
        expect_val("x5_keep", S_RD2, 64'h12345678);
        expect_val("ret_2", S_RET, 64'd2);

        // Writes to x0 are neither bypassed nor stored.
        step(); idle(); wr(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_val("x0_rd1", S_RD1, 64'd0);
        expect_val("x0_rd2", S_RD2, 64'd0);
        expect_val("x0_res", S_RES, 64'hFFFFFFFF);
        step(); idle(); rs2D = 5'd5;
        expect_val("x0_after", S_RD1, 64'd0);
        expect_val("x0_x5", S_RD2, 64'h12345678);
        expect_val("ret_3", S_RET, 64'd3);

        // Bubble with RegWriteW set: no write, no bypass, no count.
        step(); idle(); RegWriteW = 1'b1; rdW = 5'd9; ALUResultW = 32'hAAAA5555; rs1D = 5'd9;
        expect_val("bub_nobyp", S_RD1, 64'd0);
        expect_val("bub_ret", S_RET, 64'd3);
        step(); idle(); rs1D = 5'd9;
        expect_val("bub_nowrite", S_RD1, 64'd0);
        expect_val("bub_ret2", S_RET, 64'd3);

        // Ten valid non-writing instructions.
        for (int k = 0; k < 10; k++) begin
            step(); idle(); ValidW = 1'b1;
            expect_val("cnt_run", S_RET, 64'(3 + k));
        end
        step(); idle();
        expect_val("cnt_13", S_RET, 64'd13);

        // Counter wrap from a preloaded value.
        step(); idle();
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_instret;
        ValidW = 1'b1;
        expect_val("wrap_pre", S_RET, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        expect_val("wrap_max", S_RET, 64'hFFFF_FFFF_FFFF_FFFF);
        step(); idle();
        expect_val("wrap_zero", S_RET, 64'd0);

        // Asynchronous reset between edges.
        step(); idle(); rs1D = 5'd5; rs2D = 5'd7;
        expect_val("pre_ar_x5", S_RD1, 64'h12345678);
        expect_val("pre_ar_x7", S_RD2, 64'hDEADBEEF);
        @(negedge clk);
        #2;
        rst = 1'b0;
        wr(5'd11, 32'h11111111, 5'd11, 5'd5);
        #1;
        expect_val("ar_rd1", S_RD1, 64'd0);
        expect_val("ar_rd2", S_RD2, 64'd0);
        expect_val("ar_ret", S_RET, 64'd0);
        -> ev_chk;
        step();
        rst = 1'b1;
        idle(); rs1D = 5'd11; rs2D = 5'd7;
        expect_val("ar_drop_x11", S_RD1, 64'd0);
        expect_val("ar_x7", S_RD2, 64'd0);
        expect_val("ar_ret_hold", S_RET, 64'd0);
        step(); idle(); rs1D = 5'd5;
        expect_val("ar_x5", S_RD1, 64'd0);

        // Let the monitor drain, bounded.
        for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d checks left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation time 50000 reached, expected earlier finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage plus architectural register file of the pipelined RV32I core. Consumes the MEM/WB pipeline register outputs, selects and sign/zero-extends the writeback result, and commits it to the 32 x 32-bit integer register file. Serves the decode stage's two combinational read ports with same-cycle write bypass. Keeps a retired-instruction counter.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural register count; x0 hardwired to zero
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset); clears register file and counter immediately
- ValidW  in  1  WB slot holds a real (non-bubble) instruction
- RegWriteW  in  1  instruction writes rd
- ResultSrcW  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- Funct3W  in  3  load size/sign code
- ALUResultW  in  XLEN  ALU result; bits [1:0] are the load byte offset
- ReadDataW  in  XLEN  raw aligned word from data memory
- PCPlus4W  in  XLEN  link value for JAL/JALR
- rdW  in  5  destination register
- rs1D, rs2D  in  5  decode-stage source indices
- RD1D, RD2D  out  XLEN  source operands
- ResultW  out  XLEN  final writeback value, also fed to the forwarding muxes
- InstRetW  out  64  retired-instruction count

## Operation
- Load extension (ResultSrcW=01), offset o = ALUResultW[1:0]:
  - 000 LB: byte lane o, sign-extended; 100 LBU: zero-extended
  - 001 LH: halfword lane o[1], sign-extended; 101 LHU: zero-extended; o[0] ignored (misalignment trapped upstream)
  - 010 LW: full word, offset ignored
  - 011/110/111: raw ReadDataW
- ResultW combinational from the select above; independent of ValidW/RegWriteW.
- Commit: we = ValidW & RegWriteW & (rdW != 0). On rising edge with rst=1 and we=1, regs[rdW] <= ResultW.
- Reads: RDxD = 0 if rsxD == 0; else ResultW if we and rsxD == rdW (write-first bypass); else regs[rsxD].
- InstRetW increments by 1 on every rising edge with ValidW=1 (independent of RegWriteW); wraps 2^64-1 -> 0.

## Timing
- Reset: while rst=0, all regs = 0, InstRetW = 0, RD1D/RD2D = 0 (no bypass during reset); ResultW still combinational.
- Reset asserted mid-operation: clears asynchronously, without waiting for a clock edge; a write coincident with the edge at which rst is low is dropped.
- Deassertion: first commit occurs on the first rising edge with rst=1.
- Write latency: value visible via bypass in the same cycle, from the array from the next cycle.
- rdW = 0 with RegWriteW=1: no write, no bypass, reads of x0 stay 0.
- rs1D == rs2D == rdW: both ports bypass.
- No stall/flush input: bubbles arrive as ValidW=0.

## Structure
- riscv_pkg: ResultSrc encodings (RES_ALU, RES_LOAD, RES_PC4), load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module load_extend: combinational ReadDataW/offset/funct3 -> extended word.
- Register array as flip-flops, not inferred RAM: async reset clear required.

## Test plan
- Reset: hold rst=0, drive writes -> RD1D=RD2D=0, InstRetW=0; release rst, write x5=0x12345678 -> next cycle RD1D(rs1D=5)=0x12345678.
- Load extension: ReadDataW=0x80FF7F01, LB o=3 -> 0xFFFFFF80; LBU o=1 -> 0x0000007F; LH o=2 -> 0xFFFF80FF; LHU o=0 -> 0x00007F01; LW -> 0x80FF7F01.
- Bypass: same cycle write x7=0xDEADBEEF and rs1D=rs2D=7 -> both RDxD=0xDEADBEEF before the edge.
- x0: RegWriteW=1, rdW=0, ALUResultW=0xFFFFFFFF -> RD1D(rs1D=0)=0, no bypass, array unchanged.
- Bubbles/counter: ValidW=0 with RegWriteW=1 -> no write, InstRetW unchanged; 10 valid cycles -> InstRetW=10; preload near 2^64-1 via forced state -> wraps to 0.
- Async reset mid-run: pull rst low between edges after writes -> regs and InstRetW read 0 immediately.
